multi_timer: RTL and testbench

//   Multi-channel down-counting timer for the CPU memory-mapped peripheral bus.
//   A single clk_cpu domain drives an internal prescaler tick; there is no

---
 rtl/multi_timer.sv | 118 +++++++++++
 tb/tb_multi_timer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timer.sv
// Multi-channel down-counting timer with shared prescaler, bus-mapped registers
// and a sticky per-channel expired flag feeding a single interrupt line.
module multi_timer #(
    parameter int unsigned NCH      = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PRESCALE = 50_000_000,
    localparam int unsigned AW      = $clog2(NCH) + 2
) (
    input  logic            clk_cpu,
    input  logic            rst_n,
    input  logic [AW-1:0]   addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [NCH-1:0]  expired,
    output logic            irq
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             tick;
    logic [AW-1:0]    ch_sel;
    logic [1:0]       reg_sel;
    logic [NCH-1:0]   wr_ch;
    logic [NCH-1:0]   exp_set;
    logic [NCH-1:0]   ie;

    logic [WIDTH-1:0] count_q  [NCH];
    logic [WIDTH-1:0] count_d  [NCH];
    logic [WIDTH-1:0] reload_q [NCH];
    logic [WIDTH-1:0] reload_d [NCH];
    logic [2:0]       ctrl_q   [NCH];
    logic [2:0]       ctrl_d   [NCH];
    logic [NCH-1:0]   expired_q, expired_d;

    assign tick    = (pcnt_q == PW'(PRESCALE - 1));
    assign pcnt_d  = tick ? '0 : pcnt_q + PW'(1);
    assign ch_sel  = addr >> 2;
    assign reg_sel = addr[1:0];

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            wr_ch[i] = we && (ch_sel == AW'(i));
        end
    end

    always_comb begin
        exp_set   = '0;
        expired_d = expired_q;
        for (int i = 0; i < NCH; i++) begin
            count_d[i]  = count_q[i];
            reload_d[i] = reload_q[i];
            ctrl_d[i]   = ctrl_q[i];
            if (tick && ctrl_q[i][0]) begin
                if (count_q[i] > WIDTH'(1)) begin
                    count_d[i] = count_q[i] - WIDTH'(1);
                end else if (count_q[i] == WIDTH'(1)) begin
                    exp_set[i] = 1'b1;
                    count_d[i] = ctrl_q[i][1] ? reload_q[i] : '0;
                end
            end
            // A COUNT write overrides the tick entirely, including its expiry.
            if (wr_ch[i]) begin
                case (reg_sel)
                    2'd0: begin
                        count_d[i] = wdata[WIDTH-1:0];
                        exp_set[i] = 1'b0;
                    end
                    2'd1:    reload_d[i] = wdata[WIDTH-1:0];
                    2'd2:    ctrl_d[i]   = wdata[2:0];
                    default: ;
                endcase
            end
            expired_d[i] = exp_set[i] |
                           (expired_q[i] & ~(wr_ch[i] && (reg_sel == 2'd3) && wdata[0]));
        end
    end

    always_ff @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q    <= '0;
            expired_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                count_q[i]  <= '0;
                reload_q[i] <= '0;
                ctrl_q[i]   <= '0;
            end
        end else begin
            pcnt_q    <= pcnt_d;
            expired_q <= expired_d;
            for (int i = 0; i < NCH; i++) begin
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
                ctrl_q[i]   <= ctrl_d[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            ie[i] = ctrl_q[i][2];
            if (ch_sel == AW'(i)) begin
                case (reg_sel)
                    2'd0:    rdata = 32'(count_q[i]);
                    2'd1:    rdata = 32'(reload_q[i]);
                    2'd2:    rdata = 32'(ctrl_q[i]);
                    default: rdata = 32'(expired_q[i]);
                endcase
            end
        end
    end

    assign expired = expired_q;
    assign irq     = |(expired_q & ie);

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: a 4-channel 32-bit instance for the timing cases
// and a 5-channel 8-bit instance for out-of-range channels and width truncation.
`timescale 1ns/1ps
module tb_multi_timer;

    logic        clk_cpu = 1'b0;
    logic        rst_n;

    logic [3:0]  addr_a;
    logic        we_a;
    logic [31:0] wdata_a, rdata_a;
    logic [3:0]  exp_a;
    logic        irq_a;

    logic [4:0]  addr_b;
    logic        we_b;
    logic [31:0] wdata_b, rdata_b;
    logic [4:0]  exp_b;
    logic        irq_b;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [1:0]  m_pcnt;

    multi_timer #(.NCH(4), .WIDTH(32), .PRESCALE(4)) u_dut_a (
        .clk_cpu (clk_cpu),
        .rst_n   (rst_n),
        .addr    (addr_a),
        .we      (we_a),
        .wdata   (wdata_a),
        .rdata   (rdata_a),
        .expired (exp_a),
        .irq     (irq_a)
    );

    multi_timer #(.NCH(5), .WIDTH(8), .PRESCALE(4)) u_dut_b (
        .clk_cpu (clk_cpu),
        .rst_n   (rst_n),
        .addr    (addr_b),
        .we      (we_b),
        .wdata   (wdata_b),
        .rdata   (rdata_b),
        .expired (exp_b),
        .irq     (irq_b)
    );

    always #50 clk_cpu = ~clk_cpu;

    // Expected prescaler phase; value 3 means the coming rising edge is a tick.
    always @(posedge clk_cpu or negedge rst_n) begin
        if (!rst_n) m_pcnt <= 2'd0;
        else        m_pcnt <= m_pcnt + 2'd1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input bit b, input int a, input logic [31:0] d);
        if (b) begin
            addr_b = a[4:0]; wdata_b = d; we_b = 1'b1;
        end else begin
            addr_a = a[3:0]; wdata_a = d; we_a = 1'b1;
        end
        @(posedge clk_cpu);
        @(negedge clk_cpu);
        we_a = 1'b0;
        we_b = 1'b0;
    endtask

    task automatic chk_rd(input bit b, input int a, input logic [31:0] exp, input string tag);
        logic [31:0] v;
        if (b) addr_b = a[4:0];
        else   addr_a = a[3:0];
        #1;
        v = b ? rdata_b : rdata_a;
        check_eq(tag, v, exp);
    endtask

    task automatic pre_tick();
        int g = 0;
        while (m_pcnt != 2'd3 && g < 8) begin
            @(negedge clk_cpu);
            g++;
        end
        if (m_pcnt != 2'd3) begin
            n_err++;
            $display("FAIL tick_align: phase %0d never reached 3", m_pcnt);
        end
    endtask

    task automatic tick_step();
        pre_tick();
        @(posedge clk_cpu);
        @(negedge clk_cpu);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        addr_a = '0; we_a = 1'b0; wdata_a = '0;
        addr_b = '0; we_b = 1'b0; wdata_b = '0;
        repeat (2) @(negedge clk_cpu);
        rst_n = 1'b1;

        // Reset state
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) chk_rd(0, c * 4 + r, 32'h0, "rst_reg");
        end
        check_eq("rst_irq", {31'b0, irq_a}, 32'h0);
        check_eq("rst_exp", {28'b0, exp_a}, 32'h0);
        check_eq("rst_irq_b", {31'b0, irq_b}, 32'h0);

        // One-shot on ch0 with ie
        wr(0, 0, 32'd3);
        wr(0, 2, 32'd5);
        pre_tick();
        chk_rd(0, 0, 32'd3, "os_cnt_init");
        chk_rd(0, 2, 32'd5, "os_ctrl");
        tick_step();
        chk_rd(0, 0, 32'd2, "os_cnt_t1");
        tick_step();
        chk_rd(0, 0, 32'd1, "os_cnt_t2");
        check_eq("os_exp_t2", {31'b0, exp_a[0]}, 32'h0);
        tick_step();
        chk_rd(0, 0, 32'd0, "os_cnt_t3");
        check_eq("os_exp_t3", {31'b0, exp_a[0]}, 32'h1);
        check_eq("os_irq_t3", {31'b0, irq_a}, 32'h1);
        tick_step();
        chk_rd(0, 0, 32'd0, "os_hold");
        chk_rd(0, 3, 32'd1, "os_status");
        wr(0, 3, 32'd1);
        check_eq("os_clr_exp", {31'b0, exp_a[0]}, 32'h0);
        check_eq("os_clr_irq", {31'b0, irq_a}, 32'h0);

        // Auto-reload with reload==0 on ch0, no ie
        wr(0, 2, 32'd3);
        wr(0, 0, 32'd1);
        tick_step();
        chk_rd(0, 0, 32'd0, "ar0_cnt");
        check_eq("ar0_exp", {31'b0, exp_a[0]}, 32'h1);
        check_eq("ar0_irq", {31'b0, irq_a}, 32'h0);
        wr(0, 3, 32'd1);
        tick_step();
        chk_rd(0, 0, 32'd0, "ar0_hold");
        check_eq("ar0_no_refire", {31'b0, exp_a[0]}, 32'h0);
        wr(0, 2, 32'd0);

        // Auto-reload on ch1, period 2, ie=0
        wr(0, 5, 32'd2);
        wr(0, 4, 32'd2);
        wr(0, 6, 32'd3);
        tick_step();
        chk_rd(0, 4, 32'd1, "ar_t1");
        tick_step();
        chk_rd(0, 4, 32'd2, "ar_t2_reload");
        check_eq("ar_exp_t2", {31'b0, exp_a[1]}, 32'h1);
        check_eq("ar_irq_t2", {31'b0, irq_a}, 32'h0);
        tick_step();
        chk_rd(0, 4, 32'd1, "ar_t3");
        wr(0, 7, 32'd0);
        check_eq("ar_wr0_noop", {31'b0, exp_a[1]}, 32'h1);
        wr(0, 7, 32'd1);
        check_eq("ar_clr", {31'b0, exp_a[1]}, 32'h0);
        tick_step();
        chk_rd(0, 4, 32'd2, "ar_t4_reload");
        check_eq("ar_exp_t4", {31'b0, exp_a[1]}, 32'h1);
        check_eq("ar_irq_t4", {31'b0, irq_a}, 32'h0);
        wr(0, 6, 32'd0);
        wr(0, 7, 32'd1);
        chk_rd(0, 7, 32'd0, "ar_status_off");

        // Write-vs-tick priority on ch2
        wr(0, 8, 32'd5);
        wr(0, 10, 32'd5);
        pre_tick();
        wr(0, 8, 32'd9);
        chk_rd(0, 8, 32'd9, "pri_cnt_wr");
        tick_step();
        chk_rd(0, 8, 32'd8, "pri_cnt_next");
        wr(0, 8, 32'd1);
        pre_tick();
        wr(0, 11, 32'd1);
        check_eq("pri_exp_wins", {31'b0, exp_a[2]}, 32'h1);
        check_eq("pri_irq", {31'b0, irq_a}, 32'h1);
        chk_rd(0, 8, 32'd0, "pri_cnt_zero");
        wr(0, 11, 32'd1);
        check_eq("pri_clr", {31'b0, exp_a[2]}, 32'h0);
        check_eq("pri_clr_irq", {31'b0, irq_a}, 32'h0);

        // Asynchronous reset mid-count
        wr(0, 12, 32'd7);
        wr(0, 14, 32'd5);
        wr(0, 0, 32'd1);
        wr(0, 2, 32'd5);
        tick_step();
        check_eq("mid_pre_irq", {31'b0, irq_a}, 32'h1);
        #20;
        rst_n = 1'b0;
        #1;
        check_eq("mid_irq", {31'b0, irq_a}, 32'h0);
        check_eq("mid_exp", {28'b0, exp_a}, 32'h0);
        chk_rd(0, 12, 32'd0, "mid_cnt3");
        chk_rd(0, 14, 32'd0, "mid_ctrl3");
        chk_rd(0, 9, 32'd0, "mid_reload2");
        @(negedge clk_cpu);
        rst_n = 1'b1;

        // Out-of-range channel on the 5-channel instance
        wr(1, 20, 32'h55);
        chk_rd(1, 20, 32'd0, "oor_rd");
        chk_rd(1, 4, 32'd0, "oor_alias");
        wr(1, 16, 32'h12);
        chk_rd(1, 16, 32'h12, "ch4_rd");

        // Width truncation and enable gating on the 8-bit instance
        wr(1, 0, 32'h1FF);
        chk_rd(1, 0, 32'hFF, "w8_cnt");
        wr(1, 1, 32'h1AB);
        chk_rd(1, 1, 32'hAB, "w8_reload");
        wr(1, 2, 32'hF8);
        chk_rd(1, 2, 32'h0, "w8_ctrl_mask");
        repeat (10) tick_step();
        chk_rd(1, 0, 32'hFF, "w8_en0_hold");
        wr(1, 2, 32'd1);
        chk_rd(1, 2, 32'd1, "w8_ctrl_en");
        tick_step();
        chk_rd(1, 0, 32'hFE, "w8_dec");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
